cpu_datapath: RTL and testbench

Single-bus 32-bit CPU datapath: sixteen general-purpose registers, PC, HI/LO, MAR, MDR, InPort and C registers, Y/Z ALU staging registers and a combinational ALU. All are joined by one 32-bit bus with one-hot source selection. An external control unit or bench sequences the load/drive strobes each cycle. The block sits between the control unit and memory.

---
 rtl/cpu_datapath.sv | 155 +++++++++++++++
 tb/tb_cpu_datapath.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_datapath.sv
// Single-bus 32-bit CPU datapath: register file, special registers,
// Y/Z ALU staging and a combinational ALU joined by one priority-muxed bus.
module cpu_datapath (
    input  logic        clk,
    input  logic        clr,
    input  logic        R0in,
    input  logic        R1in,
    input  logic        R2in,
    input  logic        R3in,
    input  logic        R4in,
    input  logic        R5in,
    input  logic        R6in,
    input  logic        R7in,
    input  logic        R8in,
    input  logic        R9in,
    input  logic        R10in,
    input  logic        R11in,
    input  logic        R12in,
    input  logic        R13in,
    input  logic        R14in,
    input  logic        R15in,
    input  logic        PCin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        Yin,
    input  logic        Zin,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic        InPortin,
    input  logic        Cin,
    input  logic        R0out,
    input  logic        R1out,
    input  logic        R2out,
    input  logic        R3out,
    input  logic        R4out,
    input  logic        R5out,
    input  logic        R6out,
    input  logic        R7out,
    input  logic        R8out,
    input  logic        R9out,
    input  logic        R10out,
    input  logic        R11out,
    input  logic        R12out,
    input  logic        R13out,
    input  logic        R14out,
    input  logic        R15out,
    input  logic        PCout,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        ZHighOut,
    input  logic        ZLowOut,
    input  logic        MDRout,
    input  logic        InPortOut,
    input  logic        Cout,
    input  logic        incPC,
    input  logic        Read,
    input  logic [4:0]  opcode,
    input  logic [31:0] Mdatain,
    output logic [31:0] BusMuxOut
);

    logic [15:0] rin;
    logic [15:0] rout;
    logic [31:0] r [16];
    logic [31:0] pc, hi, lo, y, mar, mdr, inport, c;
    logic [63:0] z;
    logic [31:0] bus;
    logic [63:0] alu;

    assign rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
    assign rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                   R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

    // Later assignments override earlier ones, so R0 ends up highest priority.
    always_comb begin
        bus = '0;
        if (Cout)      bus = c;
        if (InPortOut) bus = inport;
        if (MDRout)    bus = mdr;
        if (PCout)     bus = pc;
        if (ZLowOut)   bus = z[31:0];
        if (ZHighOut)  bus = z[63:32];
        if (LOout)     bus = lo;
        if (HIout)     bus = hi;
        for (int i = 15; i >= 0; i--)
            if (rout[i]) bus = r[i];
    end

    assign BusMuxOut = bus;

    logic [4:0]         sh;
    logic [63:0]        rot_r, rot_l;
    logic signed [63:0] prod;
    logic signed [31:0] quot, rem;

    assign sh    = bus[4:0];
    assign rot_r = {y, y} >> sh;
    assign rot_l = {y, y} << sh;
    assign prod  = $signed({{32{y[31]}}, y}) * $signed({{32{bus[31]}}, bus});
    assign quot  = $signed(y) / $signed(bus);
    assign rem   = $signed(y) % $signed(bus);

    always_comb begin
        alu = '0;
        if (incPC) begin
            alu[31:0] = bus + 32'd1;
        end else begin
            case (opcode)
                5'b00011: alu[31:0] = y + bus;
                5'b00100: alu[31:0] = y - bus;
                5'b00101: alu[31:0] = y >> sh;
                5'b00110: alu[31:0] = y << sh;
                5'b00111: alu[31:0] = $signed(y) >>> sh;
                5'b01000: alu[31:0] = rot_r[31:0];
                5'b01001: alu[31:0] = rot_l[63:32];
                5'b01010: alu[31:0] = y & bus;
                5'b01011: alu[31:0] = y | bus;
                5'b01111: alu = prod;
                5'b10000: if (bus != '0) alu = {rem, quot};
                5'b10001: alu[31:0] = 32'd0 - bus;
                5'b10010: alu[31:0] = ~bus;
                default:  alu = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) r[i] <= '0;
            pc     <= '0;
            hi     <= '0;
            lo     <= '0;
            y      <= '0;
            z      <= '0;
            mar    <= '0;
            mdr    <= '0;
            inport <= '0;
            c      <= '0;
        end else begin
            for (int i = 0; i < 16; i++)
                if (rin[i]) r[i] <= bus;
            if (PCin)     pc     <= bus;
            if (HIin)     hi     <= bus;
            if (LOin)     lo     <= bus;
            if (Yin)      y      <= bus;
            if (Zin)      z      <= alu;
            if (MARin)    mar    <= bus;
            if (MDRin)    mdr    <= Read ? Mdatain : bus;
            if (InPortin) inport <= bus;
            if (Cin)      c      <= bus;
        end
    end

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed vector table,
// hand sequences and randomized ALU ops against a reference model.
module tb_cpu_datapath;

    localparam int I_PC = 16, I_HI = 17, I_LO = 18, I_Y = 19, I_Z = 20;
    localparam int I_MAR = 21, I_MDR = 22, I_IN = 23, I_C = 24;
    localparam int O_HI = 16, O_LO = 17, O_ZH = 18, O_ZL = 19, O_PC = 20;
    localparam int O_MDR = 21, O_IN = 22, O_C = 23;

    logic        clk = 1'b0;
    logic        clr;
    logic [24:0] ien;
    logic [23:0] osel;
    logic        incPC, Read;
    logic [4:0]  opcode;
    logic [31:0] Mdatain;
    logic [31:0] BusMuxOut;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_datapath dut (
        .clk(clk), .clr(clr),
        .R0in(ien[0]), .R1in(ien[1]), .R2in(ien[2]), .R3in(ien[3]),
        .R4in(ien[4]), .R5in(ien[5]), .R6in(ien[6]), .R7in(ien[7]),
        .R8in(ien[8]), .R9in(ien[9]), .R10in(ien[10]), .R11in(ien[11]),
        .R12in(ien[12]), .R13in(ien[13]), .R14in(ien[14]), .R15in(ien[15]),
        .PCin(ien[I_PC]), .HIin(ien[I_HI]), .LOin(ien[I_LO]),
        .Yin(ien[I_Y]), .Zin(ien[I_Z]), .MARin(ien[I_MAR]),
        .MDRin(ien[I_MDR]), .InPortin(ien[I_IN]), .Cin(ien[I_C]),
        .R0out(osel[0]), .R1out(osel[1]), .R2out(osel[2]), .R3out(osel[3]),
        .R4out(osel[4]), .R5out(osel[5]), .R6out(osel[6]), .R7out(osel[7]),
        .R8out(osel[8]), .R9out(osel[9]), .R10out(osel[10]), .R11out(osel[11]),
        .R12out(osel[12]), .R13out(osel[13]), .R14out(osel[14]), .R15out(osel[15]),
        .PCout(osel[O_PC]), .HIout(osel[O_HI]), .LOout(osel[O_LO]),
        .ZHighOut(osel[O_ZH]), .ZLowOut(osel[O_ZL]), .MDRout(osel[O_MDR]),
        .InPortOut(osel[O_IN]), .Cout(osel[O_C]),
        .incPC(incPC), .Read(Read), .opcode(opcode),
        .Mdatain(Mdatain), .BusMuxOut(BusMuxOut)
    );

    typedef struct {
        string       nm;
        logic [4:0]  op;
        bit          inc;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] e;
    } vec_t;

    vec_t tv[$];

    function automatic logic [63:0] ref_alu(input logic [4:0] op, input bit inc,
                                            input logic [31:0] a, input logic [31:0] b);
        int          n  = int'(b[4:0]);
        int          ai = a;
        int          bi = b;
        longint      p;
        logic [31:0] v  = '0;
        if (inc) return {32'd0, b + 32'd1};
        case (op)
            5'd3:  v = a + b;
            5'd4:  v = a - b;
            5'd5:  v = a >> n;
            5'd6:  v = a << n;
            5'd7:  v = a[31] ? ~((~a) >> n) : (a >> n);
            5'd8:  v = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
            5'd9:  v = (n == 0) ? a : ((a << n) | (a >> (32 - n)));
            5'd10: v = a & b;
            5'd11: v = a | b;
            5'd15: begin
                p = longint'(ai) * longint'(bi);
                return p;
            end
            5'd16: begin
                if (bi == 0) return 64'd0;
                return {32'(ai % bi), 32'(ai / bi)};
            end
            5'd17: v = -b;
            5'd18: v = ~b;
            default: v = '0;
        endcase
        return {32'd0, v};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        ien = '0; osel = '0; incPC = 1'b0; Read = 1'b0; opcode = '0; Mdatain = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int s, output logic [31:0] v);
        idle();
        osel[s] = 1'b1;
        #1;
        v = BusMuxOut;
        osel[s] = 1'b0;
    endtask

    task automatic put(input logic [31:0] v, input int dst);
        idle();
        Mdatain = v; Read = 1'b1; ien[I_MDR] = 1'b1;
        tick();
        idle();
        osel[O_MDR] = 1'b1; ien[dst] = 1'b1;
        tick();
        idle();
    endtask

    task automatic alu_run(input int ra, input int rb, input logic [4:0] op, input bit inc);
        idle();
        osel[ra] = 1'b1; ien[I_Y] = 1'b1;
        tick();
        idle();
        osel[rb] = 1'b1; opcode = op; incPC = inc; ien[I_Z] = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] v, w;
        logic [63:0] e;
        int          ra, rb, rd_i;
        logic [4:0]  op;
        bit          inc;
        logic [4:0]  ops [17] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                  5'd11, 5'd15, 5'd16, 5'd17, 5'd18, 5'd0, 5'd1,
                                  5'd12, 5'd31};

        tv.push_back('{"shra_pos", 5'b00111, 1'b0, 32'd32, 32'd2, 64'd8});
        tv.push_back('{"shra_neg", 5'b00111, 1'b0, 32'hFFFFFFE0, 32'd2, 64'h00000000_FFFFFFF8});
        tv.push_back('{"mul", 5'b01111, 1'b0, 32'hFFFFFFFA, 32'd4, 64'hFFFFFFFF_FFFFFFE8});
        tv.push_back('{"div", 5'b10000, 1'b0, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD});
        tv.push_back('{"div_negdvd", 5'b10000, 1'b0, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD});
        tv.push_back('{"div_zero", 5'b10000, 1'b0, 32'd7, 32'd0, 64'd0});
        tv.push_back('{"shr", 5'b00101, 1'b0, 32'h80000001, 32'd1, 64'h40000000});
        tv.push_back('{"shl", 5'b00110, 1'b0, 32'h80000001, 32'd1, 64'h00000002});
        tv.push_back('{"ror", 5'b01000, 1'b0, 32'h80000001, 32'd1, 64'hC0000000});
        tv.push_back('{"rol", 5'b01001, 1'b0, 32'h80000001, 32'd1, 64'h00000003});
        tv.push_back('{"and", 5'b01010, 1'b0, 32'h80000001, 32'h0F0F0F0F, 64'h00000001});
        tv.push_back('{"or", 5'b01011, 1'b0, 32'h80000001, 32'h0F0F0F0F, 64'h8F0F0F0F});
        tv.push_back('{"not", 5'b10010, 1'b0, 32'h80000001, 32'h0F0F0F0F, 64'hF0F0F0F0});
        tv.push_back('{"neg", 5'b10001, 1'b0, 32'h80000001, 32'h0F0F0F0F, 64'hF0F0F0F1});
        tv.push_back('{"add", 5'b00011, 1'b0, 32'd5, 32'd7, 64'd12});
        tv.push_back('{"sub", 5'b00100, 1'b0, 32'd5, 32'd7, 64'h00000000_FFFFFFFE});
        tv.push_back('{"undef0", 5'b00000, 1'b0, 32'd5, 32'd7, 64'd0});
        tv.push_back('{"undef12", 5'b01100, 1'b0, 32'd5, 32'd7, 64'd0});
        tv.push_back('{"incpc", 5'b00011, 1'b1, 32'd100, 32'd41, 64'd42});

        idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int s = 0; s < 24; s++) begin
            rd(s, v);
            chk($sformatf("init_src%0d", s), {32'd0, v}, 64'd0);
        end

        // load path
        idle();
        Mdatain = 32'd32; Read = 1'b1; ien[I_MDR] = 1'b1;
        tick();
        idle();
        osel[O_MDR] = 1'b1; ien[3] = 1'b1;
        #1;
        chk("load_bus", {32'd0, BusMuxOut}, 64'd32);
        tick();
        rd(3, v);
        chk("load_r3", {32'd0, v}, 64'd32);

        foreach (tv[k]) begin
            put(tv[k].a, 3);
            put(tv[k].b, 5);
            alu_run(3, 5, tv[k].op, tv[k].inc);
            osel[O_ZL] = 1'b1; ien[1] = 1'b1;
            tick();
            rd(1, v);
            rd(O_ZH, w);
            chk({tv[k].nm, "_lo"}, {32'd0, v}, {32'd0, tv[k].e[31:0]});
            chk({tv[k].nm, "_hi"}, {32'd0, w}, {32'd0, tv[k].e[63:32]});
        end

        // PC increment, opcode ignored
        put(32'd5, I_PC);
        idle();
        osel[O_PC] = 1'b1; ien[I_MAR] = 1'b1; incPC = 1'b1; ien[I_Z] = 1'b1;
        opcode = 5'b01010;
        tick();
        idle();
        osel[O_ZL] = 1'b1; ien[I_PC] = 1'b1;
        tick();
        rd(O_PC, v);
        chk("pc_inc", {32'd0, v}, 64'd6);
        chk("mar_pc", {32'd0, dut.mar}, 64'd5);

        // Z drives the bus and reloads in the same cycle
        idle();
        osel[O_ZL] = 1'b1; incPC = 1'b1; ien[I_Z] = 1'b1;
        tick();
        rd(O_ZL, v);
        chk("z_self", {32'd0, v}, 64'd7);

        // bus priority
        put(32'hAAAA0004, 4);
        put(32'hBBBB0009, 9);
        put(32'h11111111, I_HI);
        put(32'h22222222, I_C);
        idle();
        osel[4] = 1'b1; osel[9] = 1'b1; #1;
        chk("prio_r4_r9", {32'd0, BusMuxOut}, 64'hAAAA0004);
        idle();
        osel[O_HI] = 1'b1; osel[O_C] = 1'b1; osel[O_ZL] = 1'b1; #1;
        chk("prio_hi_c", {32'd0, BusMuxOut}, 64'h11111111);
        idle();
        osel[O_PC] = 1'b1; osel[O_C] = 1'b1; osel[9] = 1'b1; #1;
        chk("prio_r9_pc", {32'd0, BusMuxOut}, 64'hBBBB0009);

        // randomized ALU operations
        for (int it = 0; it < 150; it++) begin
            ra = $urandom_range(0, 15);
            rb = (ra + $urandom_range(1, 15)) % 16;
            rd_i = $urandom_range(0, 15);
            op = ops[$urandom_range(0, 16)];
            inc = ($urandom_range(0, 7) == 0);
            v = $urandom;
            case ($urandom_range(0, 3))
                0: w = $urandom_range(0, 40);
                1: w = 32'd0;
                default: w = $urandom;
            endcase
            if (v == 32'h80000000 && w == 32'hFFFFFFFF) w = 32'd3;
            e = ref_alu(op, inc, v, w);
            put(v, ra);
            put(w, rb);
            alu_run(ra, rb, op, inc);
            osel[O_ZL] = 1'b1; ien[rd_i] = 1'b1;
            tick();
            rd(rd_i, v);
            rd(O_ZH, w);
            chk($sformatf("rand%0d_op%0d_lo", it, op), {32'd0, v}, {32'd0, e[31:0]});
            chk($sformatf("rand%0d_op%0d_hi", it, op), {32'd0, w}, {32'd0, e[63:32]});
        end

        // reset with every enable high
        for (int i = 0; i < 16; i++) put(32'h100 + i, i);
        put(32'h201, I_PC);
        put(32'h202, I_HI);
        put(32'h203, I_LO);
        put(32'h204, I_MAR);
        put(32'h205, I_IN);
        put(32'h206, I_C);
        put(32'h207, I_Y);
        alu_run(2, 3, 5'b01111, 1'b0);
        put(32'h208, I_MDR);
        rd(7, v);
        chk("pre_reset_r7", {32'd0, v}, 64'h107);
        idle();
        ien = '1; Read = 1'b1; Mdatain = 32'hDEADBEEF; incPC = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        idle();
        for (int s = 0; s < 24; s++) begin
            rd(s, v);
            chk($sformatf("reset_src%0d", s), {32'd0, v}, 64'd0);
        end
        chk("reset_y", {32'd0, dut.y}, 64'd0);
        chk("reset_mar", {32'd0, dut.mar}, 64'd0);
        idle();
        #1;
        chk("reset_bus", {32'd0, BusMuxOut}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
